imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Parametrised, pipelined immediate generator for the decode stage of the RV pipeline. It takes instruction bits [31:7] plus an immediate-type code and produces an XLEN-wide extended immediate. The immediate is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode back-pressure never drops or duplicates an instruction. It also carries a sideband tag (PC), supports a pipeline flush, and keeps a saturating count of illegal type codes.

## Interface
- XLEN, 32 — output width; legal values 32 or 64.
- TAG_W, 32 — width of the sideband tag that travels with each immediate.
- CNT_W, 8 — width of the illegal-type counter.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst_n  in  1  — reset: one clock, asynchronous, active-low.
- in_valid  in  1  — input item present.
- in_ready  out  1  — stage can accept an item.
- immediate  in  25  — instruction bits [31:7]; im[k] = inst[k+7].
- funct  in  3  — immediate type code.
- in_tag  in  TAG_W  — sideband tag (PC).
- flush  in  1  — synchronous flush of all held items.
- out_valid  out  1  — output item present.
- out_ready  in  1  — consumer accepts the output item.
- imm  out  XLEN  — extended immediate.
- out_tag  out  TAG_W  — tag of the output item.
- out_err  out  1  — the output item had an illegal funct.
- err_cnt  out  CNT_W  — saturating count of accepted illegal items.

## Operation
- Type decode (im = immediate):
  - 000 I: sext(im[24:13]).
  - 001 S: sext({im[24:18], im[4:0]}).
  - 010 B: sext({im[24], im[0], im[23:18], im[4:1], 1'b0}).
  - 011 U: sext({im[24:5], 12'b0}); when XLEN = 64, bit 31 is replicated upward.
  - 100 J: sext({im[24], im[12:5], im[13], im[23:14], 1'b0}).
  - 101 Z (CSR zimm): zext(im[12:8]).
  - 110/111: illegal; imm = 0, err = 1.
- Sign extension always uses the top bit of the assembled field, extended to XLEN.
- Decode is combinational on the input side. The result is stored with tag and err into the main register or the skid register.
- Storage:
  - Main register (M) drives the outputs.
  - Skid register (K) holds one extra item when out_ready drops.
- States: EMPTY (M, K invalid), ONE (M valid), FULL (M and K valid).
- Accept = in_valid & in_ready & !flush. Pop = out_valid & out_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no pop → FULL (item goes to K).
  - ONE + accept + pop → ONE (new item goes to M).
  - ONE + pop, no accept → EMPTY.
  - FULL + pop → ONE (K moves to M).
  - FULL never accepts.
- in_ready = !FULL. It is registered state, not combinationally dependent on out_ready.
- flush: next state is EMPTY regardless of accept or pop in the same cycle. Flush wins over every other event. No err_cnt increment for an item presented in the flush cycle.
- err_cnt increments by 1 per accepted item with an illegal funct. It saturates at 2^CNT_W − 1 and does not wrap. Flush does not clear it.
- Order is strictly FIFO; no item is duplicated or lost unless flushed.

## Timing
- Reset values: out_valid 0, imm 0, out_tag 0, out_err 0, err_cnt 0, in_ready 1, state EMPTY.
- Reset is asynchronous on assertion and released synchronously with clk. Reset mid-operation discards all items.
- Latency: an item accepted at edge n is on the outputs after edge n (out_valid = 1 in cycle n+1).
- Throughput: 1 item/cycle while out_ready = 1.
- After out_ready falls, at most one further item is absorbed (into K); in_ready is 0 from the next cycle.
- Outputs stay stable while out_valid & !out_ready.

## Test plan
- Sign extension, I-type, funct 000, out_ready 1:
  - immediate 0x0FFE201 → imm 0x000007FF one cycle later.
  - immediate 0x1000201 → 0xFFFFF800; with XLEN 64 → 0xFFFFFFFFFFFFF800.
- All types:
  - S, immediate 0x00C2204 → 0x00000064.
  - B, 0x000C51E → 0x0000001E.
  - J, 0x003C009 → 0x0000001E.
  - U, 0x1000000 → 0x80000000 (XLEN 64: 0xFFFFFFFF80000000).
  - Z, im[12:8] = 5'b11111 → 0x1F.
- Back-pressure: stream tags 1..6 with out_ready low for 3 cycles mid-stream.
  - in_ready drops after K fills.
  - Output tag sequence is exactly 1..6 with no gaps or repeats.
- Flush:
  - FULL state + flush + in_valid in the same cycle → next cycle out_valid 0, in_ready 1.
  - The input item in the flush cycle is not delivered.
- Error counter: CNT_W 2, six accepted funct-111 items → out_err 1 and imm 0 on each; err_cnt reads 1, 2, 3, 3, 3, 3.
- Async reset: assert rst_n low mid-stream between clock edges.
  - Outputs reach reset values immediately.
  - After release, the first item emerges with latency 1.

Source files
------------

// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage_if
// Description : Handshake bundle for the immediate generator stage.
//               Input side carries an instruction fragment, type code, tag
//               and flush. Output side carries the extended immediate, tag,
//               error flag and the illegal-type counter.
//   master : drives in_valid/immediate/funct/in_tag/flush/out_ready
//   slave  : drives in_ready/out_valid/imm/out_tag/out_err/err_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      immediate;
  logic [2:0]       funct;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, immediate, funct, in_tag, flush, out_ready,
    input  in_ready, out_valid, imm, out_tag, out_err, err_cnt
  );

  modport slave (
    input  in_valid, immediate, funct, in_tag, flush, out_ready,
    output in_ready, out_valid, imm, out_tag, out_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : Pipelined RV immediate generator with a 2-entry skid buffer.
//               Decodes inst[31:7] by type code into an XLEN immediate and
//               registers it with its tag behind a valid/ready handshake.
//               Supports flush and a saturating illegal-type counter.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               bus_if  - slave side of imm_gen_stage_if (handshake bundle)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  imm_gen_stage_if.slave    bus_if
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [24:0]     w_im;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;

  assign w_im = bus_if.immediate;

  always_comb begin
    w_imm32   = 32'd0;
    w_illegal = 1'b0;
    case (bus_if.funct)
      3'b000: w_imm32 = {{20{w_im[24]}}, w_im[24:13]};
      3'b001: w_imm32 = {{20{w_im[24]}}, w_im[24:18], w_im[4:0]};
      3'b010: w_imm32 = {{19{w_im[24]}}, w_im[24], w_im[0], w_im[23:18],
                         w_im[4:1], 1'b0};
      3'b011: w_imm32 = {w_im[24:5], 12'd0};
      3'b100: w_imm32 = {{11{w_im[24]}}, w_im[24], w_im[12:5], w_im[13],
                         w_im[23:14], 1'b0};
      3'b101: w_imm32 = {27'd0, w_im[12:8]};
      default: begin
        w_imm32   = 32'd0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // Bit 31 of the 32-bit result already carries the sign (zero for Z and
  // illegal codes), so widening is a plain replication of it.
  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_xlen_32
      assign w_imm = w_imm32;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Skid buffer state
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,  state_d;
  logic [XLEN-1:0]  m_imm_q,  m_imm_d;
  logic [TAG_W-1:0] m_tag_q,  m_tag_d;
  logic             m_err_q,  m_err_d;
  logic [XLEN-1:0]  k_imm_q,  k_imm_d;
  logic [TAG_W-1:0] k_tag_q,  k_tag_d;
  logic             k_err_q,  k_err_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_pop;

  // in_ready comes straight from the state register, never from out_ready.
  assign w_in_ready  = (state_q != ST_FULL);
  assign w_out_valid = (state_q != ST_EMPTY);
  assign w_accept    = bus_if.in_valid & w_in_ready & ~bus_if.flush;
  assign w_pop       = w_out_valid & bus_if.out_ready;

  always_comb begin
    state_d = state_q;
    m_imm_d = m_imm_q;
    m_tag_d = m_tag_q;
    m_err_d = m_err_q;
    k_imm_d = k_imm_q;
    k_tag_d = k_tag_q;
    k_err_d = k_err_q;
    cnt_d   = cnt_q;

    if (w_accept && w_illegal && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (bus_if.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_accept) begin
            m_imm_d = w_imm;
            m_tag_d = bus_if.in_tag;
            m_err_d = w_illegal;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            m_imm_d = w_imm;
            m_tag_d = bus_if.in_tag;
            m_err_d = w_illegal;
          end else if (w_accept) begin
            // Consumer stalled: park the new item behind the head.
            k_imm_d = w_imm;
            k_tag_d = bus_if.in_tag;
            k_err_d = w_illegal;
            state_d = ST_FULL;
          end else if (w_pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            m_imm_d = k_imm_q;
            m_tag_d = k_tag_q;
            m_err_d = k_err_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      m_imm_q <= '0;
      m_tag_q <= '0;
      m_err_q <= 1'b0;
      k_imm_q <= '0;
      k_tag_q <= '0;
      k_err_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_imm_q <= m_imm_d;
      m_tag_q <= m_tag_d;
      m_err_q <= m_err_d;
      k_imm_q <= k_imm_d;
      k_tag_q <= k_tag_d;
      k_err_q <= k_err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_if.in_ready  = w_in_ready;
  assign bus_if.out_valid = w_out_valid;
  assign bus_if.imm       = m_imm_q;
  assign bus_if.out_tag   = m_tag_q;
  assign bus_if.out_err   = m_err_q;
  assign bus_if.err_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_stage
// Description : Directed self-checking bench for imm_gen_stage. Two DUTs share
//               the same stimulus: XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [24:0] immediate;
  logic [2:0]  funct;
  logic [31:0] in_tag;
  logic        flush;
  logic        out_ready;

  int total;
  int passed;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32), .CNT_W(2)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32), .CNT_W(8)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.immediate = immediate;
  assign bus32.funct     = funct;
  assign bus32.in_tag    = in_tag;
  assign bus32.flush     = flush;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.immediate = immediate;
  assign bus64.funct     = funct;
  assign bus64.in_tag    = in_tag;
  assign bus64.flush     = flush;
  assign bus64.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .CNT_W(2)) u_dut32 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .CNT_W(8)) u_dut64 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    total++;
    if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus32.out_valid);
    else passed++;
    total++;
    if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready);
    else passed++;
    total++;
    if (bus32.imm !== 32'd0 || bus64.imm !== 64'd0)
      $display("FAIL reset_imm: got %h/%h expected 0", bus32.imm, bus64.imm);
    else passed++;
    total++;
    if (bus32.out_tag !== 32'd0 || bus32.out_err !== 1'b0 || bus32.err_cnt !== 2'd0)
      $display("FAIL reset_tag_err_cnt: got %h %b %0d expected 0 0 0",
               bus32.out_tag, bus32.out_err, bus32.err_cnt);
    else passed++;
  endtask

  task automatic test_decode;
    logic [24:0] vi [12];
    logic [2:0]  vf [12];
    logic [31:0] e32 [12];
    logic [63:0] e64 [12];
    vi[0]  = 25'h0FFE201; vf[0]  = 3'b000; e32[0]  = 32'h000007FF; e64[0]  = 64'h00000000000007FF;
    vi[1]  = 25'h1000201; vf[1]  = 3'b000; e32[1]  = 32'hFFFFF800; e64[1]  = 64'hFFFFFFFFFFFFF800;
    vi[2]  = 25'h00C2204; vf[2]  = 3'b001; e32[2]  = 32'h00000064; e64[2]  = 64'h0000000000000064;
    vi[3]  = 25'h1000000; vf[3]  = 3'b001; e32[3]  = 32'hFFFFF800; e64[3]  = 64'hFFFFFFFFFFFFF800;
    vi[4]  = 25'h000C51E; vf[4]  = 3'b010; e32[4]  = 32'h0000001E; e64[4]  = 64'h000000000000001E;
    vi[5]  = 25'h1000000; vf[5]  = 3'b010; e32[5]  = 32'hFFFFF000; e64[5]  = 64'hFFFFFFFFFFFFF000;
    vi[6]  = 25'h003C009; vf[6]  = 3'b100; e32[6]  = 32'h0000001E; e64[6]  = 64'h000000000000001E;
    vi[7]  = 25'h1000000; vf[7]  = 3'b100; e32[7]  = 32'hFFF00000; e64[7]  = 64'hFFFFFFFFFFF00000;
    vi[8]  = 25'h1000000; vf[8]  = 3'b011; e32[8]  = 32'h80000000; e64[8]  = 64'hFFFFFFFF80000000;
    vi[9]  = 25'h0ABCDE0; vf[9]  = 3'b011; e32[9]  = 32'h55E6F000; e64[9]  = 64'h0000000055E6F000;
    vi[10] = 25'h0001F00; vf[10] = 3'b101; e32[10] = 32'h0000001F; e64[10] = 64'h000000000000001F;
    vi[11] = 25'h1001F00; vf[11] = 3'b101; e32[11] = 32'h0000001F; e64[11] = 64'h000000000000001F;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid  = 1'b1;
      immediate = vi[i];
      funct     = vf[i];
      in_tag    = 32'h100 + i;
      step();
      total++;
      if (bus32.out_valid !== 1'b1 || bus32.imm !== e32[i] || bus32.out_tag !== 32'h100 + i || bus32.out_err !== 1'b0)
        $display("FAIL decode32[%0d]: got v=%b imm=%h tag=%h err=%b expected v=1 imm=%h tag=%h err=0",
                 i, bus32.out_valid, bus32.imm, bus32.out_tag, bus32.out_err, e32[i], 32'h100 + i);
      else passed++;
      total++;
      if (bus64.imm !== e64[i])
        $display("FAIL decode64[%0d]: got %h expected %h", i, bus64.imm, e64[i]);
      else passed++;
    end
    in_valid = 1'b0;
    step();
    total++;
    if (bus32.out_valid !== 1'b0) $display("FAIL decode_drain: got out_valid %b expected 0", bus32.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int          nxt;
    int          got;
    bit          low_seen;
    logic [31:0] hold;
    logic [31:0] rx [8];
    nxt = 1; got = 0; low_seen = 0; hold = '0;
    funct = 3'b000; immediate = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (nxt <= 6);
      in_tag    = nxt;
      if (cyc == 2) hold = bus32.out_tag;
      if (cyc == 3 || cyc == 4) begin
        total++;
        if (bus32.out_valid !== 1'b1 || bus32.out_tag !== hold)
          $display("FAIL stall_stable[%0d]: got v=%b tag=%h expected v=1 tag=%h", cyc, bus32.out_valid, bus32.out_tag, hold);
        else passed++;
      end
      if (bus32.out_valid && out_ready) begin
        if (got < 8) rx[got] = bus32.out_tag;
        got++;
      end
      if (!bus32.in_ready) low_seen = 1'b1;
      if (in_valid && bus32.in_ready) nxt++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (got !== 6) $display("FAIL b2b_count: got %0d items expected 6", got);
    else passed++;
    total++;
    if (low_seen !== 1'b1) $display("FAIL b2b_in_ready_drop: got %b expected 1", low_seen);
    else passed++;
    for (int i = 0; i < 6 && i < got; i++) begin
      total++;
      if (rx[i] !== i + 1) $display("FAIL b2b_order[%0d]: got %0d expected %0d", i, rx[i], i + 1);
      else passed++;
    end
    step();
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    funct     = 3'b000;
    immediate = 25'h0FFE201;
    in_valid  = 1'b1;
    in_tag    = 32'hA;
    step();
    in_tag = 32'hB;
    step();
    total++;
    if (bus32.in_ready !== 1'b0 || bus32.out_tag !== 32'hA)
      $display("FAIL flush_full: got in_ready=%b tag=%h expected 0 0000000a", bus32.in_ready, bus32.out_tag);
    else passed++;
    flush = 1'b1; in_tag = 32'hC; funct = 3'b111; out_ready = 1'b1;
    step();
    total++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1)
      $display("FAIL flush_from_full: got v=%b rdy=%b expected 0 1", bus32.out_valid, bus32.in_ready);
    else passed++;
    flush = 1'b0; in_tag = 32'hD; funct = 3'b000;
    step();
    total++;
    if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'hD)
      $display("FAIL flush_next_item: got v=%b tag=%h expected 1 0000000d", bus32.out_valid, bus32.out_tag);
    else passed++;
    flush = 1'b1; in_tag = 32'hE; funct = 3'b111;
    step();
    total++;
    if (bus32.out_valid !== 1'b0 || bus32.err_cnt !== 2'd0 || bus64.err_cnt !== 8'd0)
      $display("FAIL flush_from_one: got v=%b cnt=%0d/%0d expected 0 0/0", bus32.out_valid, bus32.err_cnt, bus64.err_cnt);
    else passed++;
    flush = 1'b0; in_valid = 1'b0; funct = 3'b000;
    step();
    total++;
    if (bus32.out_valid !== 1'b0) $display("FAIL flush_dropped: got out_valid %b expected 0", bus32.out_valid);
    else passed++;
  endtask

  task automatic test_err_counter;
    int e;
    out_ready = 1'b1;
    funct     = 3'b111;
    immediate = 25'h1FFFFFF;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1;
      in_tag   = 32'h40 + k;
      step();
      e = (k > 3) ? 3 : k;
      total++;
      if (bus32.out_valid !== 1'b1 || bus32.out_err !== 1'b1 || bus32.imm !== 32'd0 || bus32.err_cnt !== e[1:0])
        $display("FAIL err_item[%0d]: got v=%b err=%b imm=%h cnt=%0d expected 1 1 00000000 %0d",
                 k, bus32.out_valid, bus32.out_err, bus32.imm, bus32.err_cnt, e);
      else passed++;
      total++;
      if (bus64.err_cnt !== k[7:0] || bus64.imm !== 64'd0)
        $display("FAIL err_cnt64[%0d]: got cnt=%0d imm=%h expected %0d 0", k, bus64.err_cnt, bus64.imm, k);
      else passed++;
    end
    in_valid = 1'b0;
    funct    = 3'b000;
    step();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    funct     = 3'b111;
    in_valid  = 1'b1;
    in_tag    = 32'h20;
    step();
    in_tag = 32'h21;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1 || bus32.out_tag !== 32'd0 ||
        bus32.out_err !== 1'b0 || bus32.err_cnt !== 2'd0 || bus64.err_cnt !== 8'd0)
      $display("FAIL async_reset: got v=%b rdy=%b tag=%h err=%b cnt=%0d/%0d expected 0 1 0 0 0/0",
               bus32.out_valid, bus32.in_ready, bus32.out_tag, bus32.out_err, bus32.err_cnt, bus64.err_cnt);
    else passed++;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 32'h30;
    funct     = 3'b000;
    immediate = 25'h0FFE201;
    out_ready = 1'b1;
    step();
    total++;
    if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'h30 || bus32.imm !== 32'h7FF)
      $display("FAIL post_reset_latency: got v=%b tag=%h imm=%h expected 1 00000030 000007ff",
               bus32.out_valid, bus32.out_tag, bus32.imm);
    else passed++;
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; immediate = '0; funct = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_decode();
    test_back_to_back();
    test_flush();
    test_err_counter();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
